bfu_barrett_pipe: RTL and testbench

// - Parametrised, multi-lane Barrett reduction unit for the PQCUARK NTT datapath.
// - Reduces LANES signed COEF_W-bit coefficients per beat modulo Q, with the mode selected per beat:
//   - centred output: Kyber-compatible, range [-(Q-1)/2, (Q-1)/2];
//   - canonical output: range [0, Q-1].
// - Fixed 3-stage pipeline with full valid/ready backpressure and synchronous flush.
// - Sits between the butterfly/accumulate units and the coefficient writeback path.

---
 rtl/pqc_barrett_pkg.sv | 14 +
 rtl/bfu_barrett_lane.sv | 76 +++++++
 rtl/bfu_barrett_pipe.sv | 110 +++++++++++
 tb/tb_bfu_barrett_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pqc_barrett_pkg.sv
// Shared constants and types for the Kyber Barrett reduction datapath.
package pqc_barrett_pkg;

  localparam int KYBER_Q             = 3329;
  localparam int KYBER_BARRETT_V     = 20159;  // round(2^26 / 3329)
  localparam int KYBER_BARRETT_SHIFT = 26;

  // Output representation selected per beat.
  typedef enum logic {
    BARRETT_CENTRED = 1'b0,  // [-(Q-1)/2, (Q-1)/2]
    BARRETT_CANON   = 1'b1   // [0, Q-1]
  } barrett_mode_e;

endpackage

// File: rtl/bfu_barrett_lane.sv
// One coefficient lane of the Barrett pipeline: S0/S1/S2 data registers and
// the arithmetic between them. Valid flags and load control live in the top.
module bfu_barrett_lane
  import pqc_barrett_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int Q      = KYBER_Q,
  parameter int V      = KYBER_BARRETT_V,
  parameter int SHIFT  = KYBER_BARRETT_SHIFT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld0_i,    // load S0 from a_i
  input  logic              ld1_i,    // load S1 from S0
  input  logic              ld2_i,    // load S2 from S1
  input  logic              canon1_i, // mode of the beat held in S1
  input  logic [COEF_W-1:0] a_i,
  output logic [COEF_W-1:0] r_o
);

  // Products and the rounding add are carried at double width, signed.
  localparam int PW = 2 * COEF_W;
  localparam logic signed [PW-1:0]     V_W   = PW'(V);
  localparam logic signed [PW-1:0]     Q_W   = PW'(Q);
  localparam logic signed [PW-1:0]     RND_W = PW'(1) << (SHIFT - 1);
  localparam logic        [COEF_W-1:0] Q_C   = COEF_W'(Q);

  logic signed [COEF_W-1:0] a0_q, a1_q;
  logic signed [PW-1:0]     t1_q;
  logic        [COEF_W-1:0] r2_q;

  logic signed [PW-1:0]     a0_ext, prod, rsum, t1_d;
  logic signed [PW-1:0]     a1_ext, diff;
  logic        [COEF_W-1:0] r_c, r2_d;
  logic                     unused_diff_hi;

  // S1 quotient estimate: t = (V*a + 2^(SHIFT-1)) >>> SHIFT.
  assign a0_ext = {{COEF_W{a0_q[COEF_W-1]}}, a0_q};
  assign prod   = a0_ext * V_W;
  assign rsum   = prod + RND_W;
  assign t1_d   = rsum >>> SHIFT;

  // S2 remainder: r = a - t*Q, wrapped to COEF_W bits; canonical mode lifts
  // negative remainders by one Q.
  assign a1_ext = {{COEF_W{a1_q[COEF_W-1]}}, a1_q};
  assign diff   = a1_ext - (t1_q * Q_W);
  assign r_c    = diff[COEF_W-1:0];
  assign r2_d   = (canon1_i && r_c[COEF_W-1]) ? (r_c + Q_C) : r_c;

  // The wrap to COEF_W bits intentionally discards the upper half.
  assign unused_diff_hi = ^diff[PW-1:COEF_W];

  // Stage data registers; each loads only when its enable is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a0_q <= '0;
      a1_q <= '0;
      t1_q <= '0;
      r2_q <= '0;
    end else begin
      if (ld0_i) begin
        a0_q <= a_i;
      end
      if (ld1_i) begin
        a1_q <= a0_q;
        t1_q <= t1_d;
      end
      if (ld2_i) begin
        r2_q <= r2_d;
      end
    end
  end

  assign r_o = r2_q;

endmodule

// File: rtl/bfu_barrett_pipe.sv
// Multi-lane 3-stage Barrett reduction pipe with backpressure and flush.
//
// Handshake: a beat moves across an interface on a clock edge where its
// valid and ready are both high. A stage advances when the stage after it
// advances or when it is empty, so bubbles collapse. Ready never depends on
// the same interface's valid; in_ready_o is combinational from out_ready_i.
// Flush drops everything in flight and blocks both interfaces that cycle.
module bfu_barrett_pipe
  import pqc_barrett_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int COEF_W = 16,
  parameter int Q      = KYBER_Q,
  parameter int V      = KYBER_BARRETT_V,
  parameter int SHIFT  = KYBER_BARRETT_SHIFT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_mode_i,
  input  logic [LANES*COEF_W-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*COEF_W-1:0] out_data_o
);

  logic          v0_q, v1_q, v2_q;
  logic          v0_d, v1_d, v2_d;
  barrett_mode_e m0_q, m1_q;
  barrett_mode_e m0_d, m1_d;
  logic          adv0, adv1, adv2;
  logic          ld0, ld1, ld2;

  assign adv2 = out_ready_i | ~v2_q;
  assign adv1 = adv2 | ~v1_q;
  assign adv0 = adv1 | ~v0_q;

  // Flush wins over load: no stage captures anything in a flush cycle.
  assign ld0 = adv0 & ~flush_i;
  assign ld1 = adv1 & ~flush_i;
  assign ld2 = adv2 & ~flush_i;

  assign in_ready_o  = adv0 & ~flush_i;
  assign out_valid_o = v2_q & ~flush_i;

  // Next-state for valid flags and modes: hold by default, shift on advance.
  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    v2_d = v2_q;
    m0_d = m0_q;
    m1_d = m1_q;
    if (flush_i) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (adv0) begin
        v0_d = in_valid_i;
        m0_d = barrett_mode_e'(in_mode_i);
      end
      if (adv1) begin
        v1_d = v0_q;
        m1_d = m0_q;
      end
      if (adv2) begin
        v2_d = v1_q;
      end
    end
  end

  // Control registers; reset clears all valids and modes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      m0_q <= BARRETT_CENTRED;
      m1_q <= BARRETT_CENTRED;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      m0_q <= m0_d;
      m1_q <= m1_d;
    end
  end

  // Mode is consumed when S1 moves into S2, so S2 needs no mode register.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bfu_barrett_lane #(
      .COEF_W (COEF_W),
      .Q      (Q),
      .V      (V),
      .SHIFT  (SHIFT)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .ld0_i    (ld0),
      .ld1_i    (ld1),
      .ld2_i    (ld2),
      .canon1_i (m1_q == BARRETT_CANON),
      .a_i      (in_data_i[k*COEF_W +: COEF_W]),
      .r_o      (out_data_o[k*COEF_W +: COEF_W])
    );
  end

endmodule

// File: tb/tb_bfu_barrett_pipe.sv
// Bench for bfu_barrett_pipe: directed value tables, backpressure, flush and
// a long random stream checked against a modular-arithmetic reference.
module tb_bfu_barrett_pipe;

  localparam int DW = 32;

  logic          clk;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          in_mode_i;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            lat_q[$];   // cycle the beat must appear in, or -1
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  bfu_barrett_pipe dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_mode_i   (in_mode_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, %0d beats outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- checking / reference ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Exact modular reduction, independent of the Barrett formulation.
  function automatic logic [15:0] ref_red(input logic [15:0] a, input logic canon);
    int ai;
    int r;
    ai = $signed(a);
    r  = ai % 3329;
    if (r < 0) r += 3329;
    if (!canon && r > 1664) r -= 3329;
    return 16'(r);
  endfunction

  function automatic logic [DW-1:0] exp_of(input logic [15:0] a, input logic canon);
    logic [15:0] na;
    na = 16'(-a);
    return {ref_red(na, canon), ref_red(a, canon)};
  endfunction

  // ---------------- drivers ----------------
  // One clock of stimulus; lane 1 always carries -lane 0. Returns acceptance.
  task automatic drive(input logic v, input logic m, input logic [15:0] a,
                       input logic fl, input logic ordy, input logic [DW-1:0] e,
                       input int lat, output logic acc);
    @(posedge clk);
    #1;
    in_valid_i  = v;
    in_mode_i   = m;
    in_data_i   = {16'(-a), a};
    flush_i     = fl;
    out_ready_i = ordy;
    @(negedge clk);
    #1;
    acc = v && in_ready_o;
    if (acc) begin
      exp_q.push_back(e);
      lat_q.push_back(lat >= 0 ? cyc + lat : -1);
    end
    if (fl) begin
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic send(input logic m, input logic [15:0] a, input logic [DW-1:0] e, input int lat);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      drive(1'b1, m, a, 1'b0, 1'b1, e, lat, acc);
      n++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      drive(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, '0, -1, acc);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    logic [DW-1:0] e;
    int            l;
    @(negedge clk);
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid_o) check("hold_stable", out_data_o, prev_data);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("outstanding_beats", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("data", out_data_o, e);
          if (l >= 0) check("latency", 32'(cyc), 32'(l));
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
    end
  end

  // ---------------- test sequence ----------------
  int t2_in[6] = '{3329, -1, 32767, -32768, 1665, 6658};
  int t2_c[6]  = '{0, -1, -523, 522, -1664, 0};
  int t3_k[5]  = '{0, 3328, 2806, 522, 1665};

  initial begin
    logic        acc;
    logic        m;
    logic        v;
    logic        hold;
    logic [15:0] a;
    int          sent;
    int          n;

    // T1 reset with a valid beat offered throughout
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b1;
    in_mode_i   = 1'b0;
    in_data_i   = 32'h1234_5678;
    out_ready_i = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    check("rst_out_valid_post", 32'(out_valid_o), 32'd0);
    check("rst_out_data", out_data_o, 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);

    // T2 centred table, back to back, exact latency
    for (int i = 0; i < 6; i++) begin
      a = 16'(t2_in[i]);
      send(1'b0, a, {ref_red(16'(-a), 1'b0), 16'(t2_c[i])}, 3);
    end
    drain();

    // T3 canonical table, then per-beat alternating modes
    for (int i = 0; i < 5; i++) begin
      a = 16'(t2_in[i]);
      send(1'b1, a, {ref_red(16'(-a), 1'b1), 16'(t3_k[i])}, 3);
    end
    for (int i = 0; i < 6; i++) begin
      a = 16'(t2_in[i]);
      m = 1'(i);
      send(m, a, exp_of(a, m), 3);
    end
    drain();

    // T4 backpressure: consumer stalls for stream cycles 4..8
    sent = 0;
    n    = 0;
    a    = 16'($urandom);
    m    = 1'($urandom_range(0, 1));
    while (sent < 10 && n < 60) begin
      drive(1'b1, m, a, 1'b0, !(n >= 4 && n <= 8), exp_of(a, m), -1, acc);
      if (n == 8) begin
        check("t4_in_ready_full", 32'(in_ready_o), 32'd0);
        check("t4_beats_held", 32'(exp_q.size()), 32'd3);
      end
      if (acc) begin
        sent++;
        a = 16'($urandom);
        m = 1'($urandom_range(0, 1));
      end
      n++;
    end
    check("t4_all_sent", 32'(sent), 32'd10);
    drain();

    // T5 flush with three beats in flight
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      m = 1'($urandom_range(0, 1));
      drive(1'b1, m, a, i == 3, 1'b1, exp_of(a, m), 3, acc);
      if (i == 3) begin
        check("t5_in_ready_flush", 32'(in_ready_o), 32'd0);
        check("t5_out_valid_flush", 32'(out_valid_o), 32'd0);
      end else begin
        check("t5_accept", 32'(acc), 32'd1);
      end
    end
    flush_i = 1'b0;
    drain();

    // T6 random stream, random backpressure and modes
    sent = 0;
    n    = 0;
    hold = 1'b0;
    v    = 1'b0;
    while (sent < 10000 && n < 60000) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        a = 16'($urandom);
        m = 1'($urandom_range(0, 1));
      end
      drive(v, m, a, 1'b0, $urandom_range(0, 3) != 0, exp_of(a, m), -1, acc);
      if (acc) sent++;
      hold = v && !acc;
      n++;
    end
    check("t6_all_sent", 32'(sent), 32'd10000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
